// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// multi-cycle MUL/DIV execute holds, plus a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int MUL_LAT        = 3,
    parameter int DIV_LAT        = 8,
    parameter int OPCODE_WIDTH   = 6,
    parameter int REG_ADDR_WIDTH = 5,
    parameter logic [OPCODE_WIDTH-1:0] OP_MUL = OPCODE_WIDTH'(12),
    parameter logic [OPCODE_WIDTH-1:0] OP_DIV = OPCODE_WIDTH'(13)
) (
    input  logic                      clk_in,
    input  logic                      RST,
    input  logic                      instr_valid,
    input  logic [OPCODE_WIDTH-1:0]   opcode_id,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_id,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_id,
    input  logic [REG_ADDR_WIDTH-1:0] rd_ex,
    input  logic                      ld_ex,
    input  logic                      branch_taken,
    input  logic                      clr_stats,
    output logic                      stall_if,
    output logic                      bubble_id,
    output logic                      flush,
    output logic                      ex_hold,
    output logic                      muldiv_done,
    output logic                      busy,
    output logic [15:0]               stall_cycles
);

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    // cnt holds the number of hold cycles still to go; the done cycle follows cnt==0.
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       load_use;

    assign load_use = instr_valid & ld_ex & ((rd_ex == rs1_id) | (rd_ex == rs2_id));

    // NOTE: every output and next-state variable gets a default first so no latch is inferred.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        stall_if    = 1'b0;
        bubble_id   = 1'b0;
        flush       = 1'b0;
        ex_hold     = 1'b0;
        muldiv_done = 1'b0;
        busy        = 1'b0;

        if (!RST) begin
            unique case (state)
                RUN: begin
                    if (branch_taken) begin
                        flush     = 1'b1;
                        bubble_id = 1'b1;
                    end else if (load_use) begin
                        stall_if  = 1'b1;
                        bubble_id = 1'b1;
                    end else if (instr_valid && opcode_id == OP_MUL) begin
                        cnt_nxt   = MUL_CNT;
                        state_nxt = WAIT;
                    end else if (instr_valid && opcode_id == OP_DIV) begin
                        cnt_nxt   = DIV_CNT;
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    busy = 1'b1;
                    if (cnt != 4'd0) begin
                        stall_if = 1'b1;
                        ex_hold  = 1'b1;
                        cnt_nxt  = cnt - 4'd1;
                    end else begin
                        muldiv_done = 1'b1;
                        state_nxt   = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_in) begin
        if (RST) begin
            state        <= RUN;
            cnt          <= 4'd0;
            stall_cycles <= 16'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (clr_stats)
                stall_cycles <= 16'd0;
            else if (stall_if && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver predicts each cycle's outputs from
// a latency-count reference model; a negedge monitor pops and compares.
module tb_hazard_ctrl;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 8;
    localparam int OW      = 6;
    localparam int AW      = 5;
    localparam logic [OW-1:0] OP_MUL = 6'h0C;
    localparam logic [OW-1:0] OP_DIV = 6'h0D;

    logic          clk_in = 1'b0;
    logic          RST = 1'b1;
    logic          instr_valid = 1'b0;
    logic [OW-1:0] opcode_id = '0;
    logic [AW-1:0] rs1_id = '0, rs2_id = '0, rd_ex = '0;
    logic          ld_ex = 1'b0, branch_taken = 1'b0, clr_stats = 1'b0;
    logic          stall_if, bubble_id, flush, ex_hold, muldiv_done, busy;
    logic [15:0]   stall_cycles;

    hazard_ctrl #(
        .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .OPCODE_WIDTH(OW), .REG_ADDR_WIDTH(AW),
        .OP_MUL(OP_MUL), .OP_DIV(OP_DIV)
    ) dut (
        .clk_in(clk_in), .RST(RST), .instr_valid(instr_valid), .opcode_id(opcode_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex), .ld_ex(ld_ex),
        .branch_taken(branch_taken), .clr_stats(clr_stats),
        .stall_if(stall_if), .bubble_id(bubble_id), .flush(flush), .ex_hold(ex_hold),
        .muldiv_done(muldiv_done), .busy(busy), .stall_cycles(stall_cycles)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [5:0]  ctl;   // {stall_if, bubble_id, flush, ex_hold, muldiv_done, busy}
        logic [15:0] sc;
        logic [31:0] cyc;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    bit   done_driving = 1'b0;

    // Reference model: remaining execute cycles of the current MUL/DIV, and the stall tally.
    int m_wait_left = 0;
    int m_stats = 0;

    task automatic check(input string name, input int c, input logic [21:0] act, input logic [21:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%h required=%h", name, c, act, req);
    endtask

    task automatic drive(input logic rst, input logic iv, input logic [OW-1:0] op,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic [AW-1:0] rd,
                         input logic ld, input logic br, input logic clr);
        exp_t e;
        logic lu, s, b, f, h, d, bz;
        @(posedge clk_in);
        #1;
        RST = rst; instr_valid = iv; opcode_id = op; rs1_id = r1; rs2_id = r2;
        rd_ex = rd; ld_ex = ld; branch_taken = br; clr_stats = clr;
        lu = iv && ld && (rd == r1 || rd == r2);
        {s, b, f, h, d, bz} = 6'b0;
        if (!rst) begin
            if (m_wait_left > 0) begin
                bz = 1'b1;
                if (m_wait_left > 1) begin s = 1'b1; h = 1'b1; end
                else d = 1'b1;
            end else if (br) begin
                f = 1'b1; b = 1'b1;
            end else if (lu) begin
                s = 1'b1; b = 1'b1;
            end
        end
        e.ctl = {s, b, f, h, d, bz};
        e.sc  = 16'(m_stats);
        e.cyc = cyc;
        q.push_back(e);
        cyc++;
        if (rst) begin
            m_wait_left = 0;
            m_stats = 0;
        end else begin
            if (m_wait_left > 0) m_wait_left--;
            else if (!br && !lu && iv && op == OP_MUL) m_wait_left = MUL_LAT;
            else if (!br && !lu && iv && op == OP_DIV) m_wait_left = DIV_LAT;
            if (clr) m_stats = 0;
            else if (s && m_stats < 65535) m_stats++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, '0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are sampled at the falling edge, half a cycle after inputs settle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("ctl", e.cyc, {stall_if, bubble_id, flush, ex_hold, muldiv_done, busy, 16'h0},
                      {e.ctl, 16'h0});
                check("stall_cycles", e.cyc, {6'h0, stall_cycles}, {6'h0, e.sc});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [OW-1:0] op;
        logic [AW-1:0] r1, r2, rd;
        // Reset state
        drive(1, 0, '0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, OP_MUL, 0, 0, 0, 0, 1, 0);
        idle(2);
        // Load-use on r3, one cycle
        drive(0, 1, 6'h01, 3, 7, 3, 1, 0, 0);
        idle(2);
        // Load-use on r0 via rs2
        drive(0, 1, 6'h01, 5, 0, 0, 1, 0, 0);
        idle(1);
        // MUL with full occupancy
        drive(0, 1, OP_MUL, 1, 2, 4, 0, 0, 0);
        idle(MUL_LAT + 1);
        // DIV with branch pulsed mid-wait
        drive(0, 1, OP_DIV, 1, 2, 4, 0, 0, 0);
        idle(3);
        drive(0, 1, 6'h02, 9, 9, 9, 1, 1, 0);
        idle(DIV_LAT);
        // Branch beats load-use and a MUL in decode
        drive(0, 1, OP_MUL, 6, 1, 6, 1, 1, 0);
        idle(2);
        // Reset in the middle of a DIV
        drive(0, 1, OP_DIV, 0, 0, 1, 0, 0, 0);
        idle(1);
        drive(1, 1, OP_DIV, 0, 0, 0, 0, 1, 0);
        idle(3);
        // MUL back-to-back with DIV in decode during wait
        drive(0, 1, OP_MUL, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < MUL_LAT; i++) drive(0, 1, OP_DIV, 2, 2, 2, 1, 1, 0);
        idle(DIV_LAT + 1);
        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 5))
                0: op = OP_MUL;
                1: op = OP_DIV;
                default: op = OW'($urandom_range(0, 63));
            endcase
            r1 = AW'($urandom_range(0, 3));
            r2 = AW'($urandom_range(0, 3));
            rd = AW'($urandom_range(0, 3));
            drive(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), op, r1, r2, rd,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 31) == 0));
        end
        idle(DIV_LAT + 1);
        // Saturation of the stall counter, then clear against a live stall
        for (int i = 0; i < 65540; i++) drive(0, 1, 6'h01, 3, 4, 3, 1, 0, 0);
        drive(0, 1, 6'h01, 3, 4, 3, 1, 0, 1);
        idle(3);
        done_driving = 1'b1;
        repeat (2) @(negedge clk_in);
        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain actual=%0d required=0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL take parameter MUL_LAT, default 3: execute-stage occupancy of MUL in cycles; legal range 2..15.
REQ-002 SHALL take parameter DIV_LAT, default 8: execute-stage occupancy of DIV in cycles; legal range 2..15.
REQ-003 SHALL use OPCODE_WIDTH, REG_ADDR_WIDTH and the MUL/DIV opcode constants from params_proc.v.
REQ-004 SHALL have port clk_in, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-006 SHALL have port instr_valid, input, 1: the decode slot holds a valid instruction.
REQ-007 SHALL have port opcode_id, input, OPCODE_WIDTH: opcode in decode.
REQ-008 SHALL have ports rs1_id and rs2_id, input, REG_ADDR_WIDTH each: decode source registers.
REQ-009 SHALL have port rd_ex, input, REG_ADDR_WIDTH: execute-stage destination register.
REQ-010 SHALL have port ld_ex, input, 1: the execute-stage instruction is LW.
REQ-011 SHALL have port branch_taken, input, 1: execute resolved a taken jump or branch.
REQ-012 SHALL have port clr_stats, input, 1: clears stall_cycles.
REQ-013 SHALL have port stall_if, output, 1: hold PC and the fetch/decode register.
REQ-014 SHALL have port bubble_id, output, 1: inject NOP into the decode/execute register.
REQ-015 SHALL have port flush, output, 1: squash the fetch/decode register.
REQ-016 SHALL have port ex_hold, output, 1: hold the execute stage.
REQ-017 SHALL have port muldiv_done, output, 1: one-cycle pulse on the final MUL/DIV cycle.
REQ-018 SHALL have port busy, output, 1: high when in state WAIT.
REQ-019 SHALL have port stall_cycles, output, 16: saturating count of cycles with stall_if=1.

Function
REQ-020 SHALL implement a two-state FSM, RUN and WAIT, plus a 4-bit down-counter cnt.
REQ-021 SHALL compute load_use = instr_valid & ld_ex & (rd_ex==rs1_id | rd_ex==rs2_id), comparing all addresses, r0 included.
REQ-022 In RUN with branch_taken=1, SHALL drive flush=1, bubble_id=1, stall_if=0 and remain in RUN; branch_taken overrides load_use and MUL/DIV start.
REQ-023 In RUN with load_use=1 and no branch, SHALL drive stall_if=1, bubble_id=1 combinationally in the same cycle and remain in RUN.
REQ-024 In RUN with no branch, no load_use, instr_valid=1 and opcode_id MUL (DIV), SHALL load cnt=MUL_LAT-1 (DIV_LAT-1) and enter WAIT, asserting no stall outputs that cycle.
REQ-025 In WAIT with cnt!=0, SHALL drive stall_if=1 and ex_hold=1, and decrement cnt.
REQ-026 In WAIT with cnt==0, SHALL drive muldiv_done=1 with stall_if=0 and ex_hold=0, and return to RUN.
REQ-027 In WAIT, SHALL ignore branch_taken, instr_valid and load_use.
REQ-028 SHALL give total execute occupancy for MUL/DIV of exactly LAT cycles: LAT-1 hold cycles plus the done cycle.
REQ-029 SHALL generate all control outputs combinationally from state, cnt and inputs; flush, bubble_id, ex_hold and muldiv_done are 0 whenever their conditions are absent.
REQ-030 SHALL increment stall_cycles on every cycle with stall_if=1, saturating at 65535.
REQ-031 When clr_stats=1, SHALL set stall_cycles to 0 at the next edge; clr_stats wins over a simultaneous increment.

Reset
REQ-032 While RST=1 at an edge, SHALL set state=RUN, cnt=0 and stall_cycles=0; reset overrides every other input, including mid-WAIT.
REQ-033 While RST=1, SHALL force stall_if, bubble_id, flush, ex_hold, muldiv_done and busy to 0.

Verification
REQ-034 Load-use: ld_ex=1, rd_ex=3, rs1_id=3, instr_valid=1 for one cycle, ld_ex=0 next -> stall_if=bubble_id=1 in that cycle only, flush=0, stall_cycles=1.
REQ-035 MUL: opcode_id=MUL valid at cycle t, MUL_LAT=3 -> stall_if=ex_hold=1 at t+1 and t+2; muldiv_done=1 with stall_if=0 at t+3; busy=0 at t+4.
REQ-036 DIV with branch_taken pulsed at t+4 -> exactly 7 hold cycles, flush never asserted, muldiv_done at t+8.
REQ-037 Simultaneous branch_taken=1 and load_use in RUN -> flush=1, bubble_id=1, stall_if=0, stall_cycles unchanged.
REQ-038 RST=1 at t+2 of a DIV -> at t+3 busy=0, all control outputs 0, stall_cycles=0.
REQ-039 Hold load_use for 65540 cycles -> stall_cycles=65535 and holds; then clr_stats=1 with stall_if=1 -> stall_cycles=0 at the next edge.
